multi_sprite_animator: RTL
==========================

Name: multi_sprite_animator

Overview:
- Parametrised successor to the fixed three-animal dot-matrix animator.
- Drives an 8x8 bicolor dot matrix by row scan. Shows N_CH sprites; each sprite is a horizontal bar on its own row band.
- A trigger pulse makes a sprite slide one position per frame tick to the opposite edge.
- Triggers are queued, never dropped. One sprite moves at a time, granted by fixed priority.

Parameters:
- N_CH, 3: number of sprite channels, 1..3.
- N_POS, 4: positions per row, one of {2,4,8}. Sprite width SPR_W = 8/N_POS columns.
- FRAME_DIV, 1000: clk1khz cycles per animation step, >=2.
- ROW_PITCH, 3: row offset between channel bands. Channel c occupies rows c*ROW_PITCH and c*ROW_PITCH+1.
- CH_COLOR, 6'b11_01_10: 2 bits per channel {r,g}, channel 0 in the LSBs. Default: ch0 red, ch1 green, ch2 yellow.

Ports:
- clk1khz, in, 1: single system clock, also the scan clock.
- rst, in, 1: asynchronous, active-low reset.
- trig, in, N_CH: per-channel request. Level sampled every cycle; a rising edge enqueues.
- off, in, 1: display blank.
- row, out, 8: active-low row select.
- r, out, 8: red column data, MSB = leftmost.
- g, out, 8: green column data.
- busy, out, 1: a sprite is moving.
- active_ch, out, max(1,$clog2(N_CH)): channel being moved; valid while busy.
- done, out, 1: one-cycle pulse on arrival.

Behaviour:
- Reset (rst=0, async):
  - row=8'hFF, r=g=0, busy=0, done=0, active_ch=0.
  - All positions 0, all side flags 0, pending mask 0, trig edge registers 0, scan counter 0, step timer 0.
- Edge detect:
  - trig_q registered. Rise on channel c (trig[c] & ~trig_q[c]) sets pending[c].
  - The set is ignored if c is the channel currently moving.
  - A repeated rise on an already-pending channel has no extra effect.
- FSM states:
  - IDLE: if pending!=0, grant the lowest set index. Clear its pending bit, load active_ch, clear the step timer, go to MOVE. busy=1 from the next cycle.
  - MOVE: the timer counts 0..FRAME_DIV-1. At FRAME_DIV-1:
    - side=0: pos+1.
    - side=1: pos-1.
    - If the new pos is the far end (N_POS-1 for side 0, 0 for side 1), go to DONE.
    - First step occurs FRAME_DIV cycles after grant. A full move takes (N_POS-1)*FRAME_DIV cycles.
  - DONE: one cycle. done=1, toggle side[active_ch], busy=0, go to IDLE.
  - Grant of the next pending channel happens at the earliest the cycle after DONE.
- A rise on another channel during MOVE is queued. A rise arriving in the same cycle as a grant is captured in pending.
- Sprite pattern for channel c: bits [7-pos*SPR_W -: SPR_W] set, all others 0. Example for N_POS=4: pos0=8'b11000000, pos3=8'b00000011.
- Scan:
  - 3-bit counter increments every cycle and wraps 7->0.
  - Registered outputs, so there is 1 cycle latency from counter to row/r/g.
  - row = ~(8'b1<<cnt).
  - If cnt is in channel c's band: r = pattern & {8{CH_COLOR[2c+1]}}, g = pattern & {8{CH_COLOR[2c]}}. Otherwise r=g=0.
- Position changes take effect on the next scan of that row. There is no separate frame register, so no mixed-channel glitch is possible.
- off=1: row=8'hFF, r=g=0 on the next edge. Animation, queue and timer continue unaffected.
- Reset mid-move: position returns to 0 and side to 0 immediately. The pending queue is lost.

Optional Feature:
- PINGPONG_EN defined:
  - A move travels to the far end, then returns to the start in the same grant.
  - Total time is 2*(N_POS-1)*FRAME_DIV cycles.
  - The side flag is unchanged at the end.
  - done pulses only after the return.
- PINGPONG_EN undefined: one-way move with side toggle, as specified in Behaviour.

Test Plan:
- Reset, FRAME_DIV=4, N_POS=4, pulse trig[0]:
  - busy rises 2 cycles after the rise (1 cycle edge detect, 1 cycle IDLE grant).
  - ch0 pos steps 0->1->2->3 at 4-cycle intervals.
  - done pulses once.
  - Rows 0/1 show r=8'b00000011 and g=0.
- Pulse trig[0] again: pos 3->2->1->0, side back to 0, done pulses, row 0 shows r=8'b11000000.
- Queue and priority:
  - With ch1 moving, pulse trig[2] then trig[0].
  - ch1 finishes; next grant is ch0, then ch2.
  - Three done pulses total, no lost request.
- Re-trigger of the active channel: during ch1 MOVE, pulse trig[1]. It is ignored; only one done for ch1.
- off=1 mid-move: row stays 8'hFF and r=g=0; the move still completes on time. Release off: ch2 (yellow) rows 6/7 show r=g=8'b00000011.
- Reset asserted at step 2 of a ch0 move: row=8'hFF immediately, busy=0. After release, row 0 shows r=8'b11000000.
- With PINGPONG_EN: trig[0] yields pos 0,1,2,3,2,1,0, one done pulse, side remains 0.

Source files
------------

// File: rtl/multi_sprite_animator.sv
// Row-scanned 8x8 bicolor animator: N_CH sprite bars, queued triggers, fixed-priority single mover.
// Define PINGPONG_EN to make every move go to the far end and back within one grant.
module multi_sprite_animator #(
  parameter int         N_CH      = 3,
  parameter int         N_POS     = 4,
  parameter int         FRAME_DIV = 1000,
  parameter int         ROW_PITCH = 3,
  parameter logic [5:0] CH_COLOR  = 6'b11_01_10,
  localparam int        AW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk1khz,
  input  logic            rst,
  input  logic [N_CH-1:0] trig,
  input  logic            off,
  output logic [7:0]      row,
  output logic [7:0]      r,
  output logic [7:0]      g,
  output logic            busy,
  output logic [AW-1:0]   active_ch,
  output logic            done
);

  localparam int SPR_W = 8 / N_POS;
  localparam int PW    = (N_POS > 2) ? $clog2(N_POS) : 1;
  localparam int TW    = $clog2(FRAME_DIV);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DONE} state_t;

  state_t          state, state_nx;
  logic [N_CH-1:0] trig_q, pending, pending_nx, rise, move_mask, grant_mask, side;
  logic [PW-1:0]   pos [N_CH];
  logic [PW-1:0]   pos_cur, pos_nx;
  logic [TW-1:0]   timer;
  logic [AW-1:0]   grant_ch;
  logic            grant, found, step, dir, at_end;
  logic            turn, ret;
  logic [2:0]      cnt;
  logic [7:0]      base, pat, row_nx, r_nx, g_nx;

  always_ff @(posedge clk1khz or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    grant      = 1'b0;
    found      = 1'b0;
    grant_ch   = '0;
    grant_mask = '0;
    move_mask  = '0;
    step       = 1'b0;
    turn       = 1'b0;
    rise       = trig & ~trig_q;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (pending[c] && !found) begin
        found    = 1'b1;
        grant_ch = AW'(c);
      end
    end
    pos_cur = pos[active_ch];
`ifdef PINGPONG_EN
    dir = side[active_ch] ^ ret;
`else
    dir = side[active_ch];
`endif
    pos_nx = dir ? pos_cur - 1'b1 : pos_cur + 1'b1;
    at_end = dir ? (pos_nx == '0) : (pos_nx == PW'(N_POS - 1));
    case (state)
      S_IDLE: if (found) begin
        grant                = 1'b1;
        grant_mask[grant_ch] = 1'b1;
        state_nx             = S_MOVE;
      end
      S_MOVE: begin
        move_mask[active_ch] = 1'b1;
        if (timer == TW'(FRAME_DIV - 1)) begin
          step = 1'b1;
          if (at_end) begin
`ifdef PINGPONG_EN
            if (!ret) turn = 1'b1;
            else      state_nx = S_DONE;
`else
            state_nx = S_DONE;
`endif
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    // a request for the channel already in motion is dropped; grant clears before new rises set
    pending_nx = (pending & ~grant_mask) | (rise & ~move_mask);
  end

  assign busy = (state == S_MOVE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk1khz or negedge rst) begin
    if (!rst) begin
      trig_q    <= '0;
      pending   <= '0;
      active_ch <= '0;
      timer     <= '0;
      side      <= '0;
      ret       <= 1'b0;
      for (int unsigned c = 0; c < N_CH; c++) pos[c] <= '0;
    end else begin
      trig_q  <= trig;
      pending <= pending_nx;
      if (grant) begin
        active_ch <= grant_ch;
        timer     <= '0;
        ret       <= 1'b0;
      end else if (state == S_MOVE) begin
        timer <= step ? '0 : timer + 1'b1;
      end
      if (step) pos[active_ch] <= pos_nx;
      if (turn) ret <= 1'b1;
`ifndef PINGPONG_EN
      if (state == S_DONE) side[active_ch] <= ~side[active_ch];
`endif
    end
  end

  always_comb begin
    base   = ~(8'hFF >> SPR_W);
    row_nx = ~(8'b1 << cnt);
    r_nx   = '0;
    g_nx   = '0;
    pat    = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (int'(cnt) == c * ROW_PITCH || int'(cnt) == c * ROW_PITCH + 1) begin
        pat  = base >> (pos[c] * SPR_W);
        r_nx = r_nx | (pat & {8{CH_COLOR[2*c+1]}});
        g_nx = g_nx | (pat & {8{CH_COLOR[2*c]}});
      end
    end
  end

  always_ff @(posedge clk1khz or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      row <= 8'hFF;
      r   <= '0;
      g   <= '0;
    end else begin
      cnt <= cnt + 3'd1;
      row <= off ? 8'hFF : row_nx;
      r   <= off ? 8'h00 : r_nx;
      g   <= off ? 8'h00 : g_nx;
    end
  end

  // PINGPONG_EN undefined leaves ret constant; keep it referenced for both builds
  logic unused_ok;
  assign unused_ok = ret;

endmodule
